// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(12,8) encoder with optional single-bit error injection,
// buffering codewords in a small FIFO ahead of the decoder / bank write path.
module hamming_enc_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [7:0]               i_data,
  input  logic                     i_err_en,
  input  logic [3:0]               i_err_pos,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [11:0]              o_code,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [CNT_W-1:0]         o_enc_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a beat transfers on a rising edge where valid && ready on that
  // side; ready/valid depend on registered occupancy only, never on the peer.

  logic [11:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;

  logic [11:0] code_raw;
  logic [11:0] err_mask;
  logic [11:0] code_in;
  logic        push;
  logic        pop;

  assign o_ready   = (count_q != CW'(DEPTH));
  assign o_valid   = (count_q != '0);
  assign o_code    = mem_q[rd_ptr_q];
  assign o_count   = count_q;
  assign o_enc_cnt = enc_cnt_q;

  // Clear wins over both handshakes: the beat presented alongside it is dropped.
  assign push = i_valid && o_ready && !i_clear;
  assign pop  = o_valid && i_ready && !i_clear;

  always_comb begin
    code_raw     = '0;
    code_raw[2]  = i_data[0];
    code_raw[4]  = i_data[1];
    code_raw[5]  = i_data[2];
    code_raw[6]  = i_data[3];
    code_raw[8]  = i_data[4];
    code_raw[9]  = i_data[5];
    code_raw[10] = i_data[6];
    code_raw[11] = i_data[7];
    code_raw[0]  = i_data[0] ^ i_data[1] ^ i_data[3] ^ i_data[4] ^ i_data[6];
    code_raw[1]  = i_data[0] ^ i_data[2] ^ i_data[3] ^ i_data[5] ^ i_data[6];
    code_raw[3]  = i_data[1] ^ i_data[2] ^ i_data[3] ^ i_data[7];
    code_raw[7]  = i_data[4] ^ i_data[5] ^ i_data[6] ^ i_data[7];

    // Positions 0 and 13..15 name no codeword bit, so they inject nothing.
    err_mask = '0;
    if (i_err_en && (i_err_pos >= 4'd1) && (i_err_pos <= 4'd12)) begin
      err_mask[i_err_pos - 4'd1] = 1'b1;
    end
    code_in = code_raw ^ err_mask;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    enc_cnt_d = enc_cnt_q;
    if (i_clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      enc_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + AW'(1);
        enc_cnt_d = enc_cnt_q + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      enc_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      enc_cnt_q <= enc_cnt_d;
    end
  end

  // Storage is zeroed on reset so an empty FIFO never shows X on o_code.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= code_in;
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Directed bench for hamming_enc_stream: vector table for encoding and error
// injection, plus sequences for full FIFO, streaming, clear and async reset.
module tb_hamming_enc_stream;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data;
  logic        err_en;
  logic [3:0]  err_pos;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] code;
  logic [2:0]  count;
  logic [15:0] enc_cnt;

  int n_checks;
  int n_fail;

  hamming_enc_stream #(.DEPTH(4), .CNT_W(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clear   (clear),
    .i_valid   (in_valid),
    .o_ready   (in_ready),
    .i_data    (data),
    .i_err_en  (err_en),
    .i_err_pos (err_pos),
    .o_valid   (out_valid),
    .i_ready   (out_ready),
    .o_code    (code),
    .o_count   (count),
    .o_enc_cnt (enc_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        err_en;
    logic [3:0]  err_pos;
    logic [11:0] code;
  } vec_t;

  vec_t vecs[14];
  logic [11:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [7:0] d, input logic en, input logic [3:0] pos);
    in_valid = 1'b1;
    data     = d;
    err_en   = en;
    err_pos  = pos;
    tick();
    in_valid = 1'b0;
    err_en   = 1'b0;
    err_pos  = 4'd0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Independent view of a codeword: XOR of set positions must be zero.
  function automatic logic [3:0] syndrome(input logic [11:0] c);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (c[i]) s = s ^ 4'(i + 1);
    end
    return s;
  endfunction

  function automatic logic [7:0] extract(input logic [11:0] c);
    return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{8'hA5, 1'b0, 4'd0,  12'hA27};
    vecs[1]  = '{8'h00, 1'b0, 4'd0,  12'h000};
    vecs[2]  = '{8'h01, 1'b0, 4'd0,  12'h007};
    vecs[3]  = '{8'hFF, 1'b0, 4'd0,  12'hF77};
    vecs[4]  = '{8'hA5, 1'b1, 4'd6,  12'hA07};
    vecs[5]  = '{8'hA5, 1'b1, 4'd0,  12'hA27};
    vecs[6]  = '{8'hA5, 1'b1, 4'd13, 12'hA27};
    vecs[7]  = '{8'hA5, 1'b1, 4'd15, 12'hA27};
    vecs[8]  = '{8'hA5, 1'b1, 4'd1,  12'hA26};
    vecs[9]  = '{8'hA5, 1'b1, 4'd12, 12'h227};
    vecs[10] = '{8'h80, 1'b0, 4'd0,  12'h888};
    vecs[11] = '{8'h10, 1'b0, 4'd0,  12'h181};
    vecs[12] = '{8'h5A, 1'b0, 4'd6,  12'h550};
    vecs[13] = '{8'hFF, 1'b1, 4'd12, 12'h777};

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    data      = 8'h00;
    err_en    = 1'b0;
    err_pos   = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_enc_cnt", enc_cnt, 0);
    check("rst_code", code, 0);
    rst_n = 1'b1;
    tick();

    // table: one beat in, check head, pop it
    for (int v = 0; v < 14; v++) begin
      push_beat(vecs[v].data, vecs[v].err_en, vecs[v].err_pos);
      check($sformatf("vec%0d_valid", v), out_valid, 1);
      check($sformatf("vec%0d_code", v), code, vecs[v].code);
      check($sformatf("vec%0d_count", v), count, 1);
      pop_one();
      check($sformatf("vec%0d_count_after_pop", v), count, 0);
      check($sformatf("vec%0d_enc_cnt", v), enc_cnt, v + 1);
    end

    // fill past full with the consumer stalled
    exp_q = {12'h181, 12'h186, 12'h198, 12'h19F};
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data = 8'h10 + 8'(k);
      tick();
      check($sformatf("full_count%0d", k), count, (k < 4) ? k + 1 : 4);
    end
    in_valid = 1'b0;
    check("full_ready", in_ready, 0);
    check("full_enc_cnt", enc_cnt, 18);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_code%0d", k), code, exp_q.pop_front());
      tick();
      check($sformatf("drain_count%0d", k), count, 3 - k);
      if (k == 0) check("drain_ready_back", in_ready, 1);
    end
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);

    // clear on an empty FIFO, then stream 20 beats back-to-back
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_enc_cnt", enc_cnt, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data = 8'(k);
      tick();
      check($sformatf("stream_valid%0d", k), out_valid, 1);
      check($sformatf("stream_count%0d", k), count, 1);
      check($sformatf("stream_syn%0d", k), syndrome(code), 0);
      check($sformatf("stream_data%0d", k), extract(code), k);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream_empty", count, 0);
    check("stream_enc_cnt", enc_cnt, 20);

    // clear with three queued while a beat and a pop are offered
    push_beat(8'h01, 1'b0, 4'd0);
    push_beat(8'h02, 1'b0, 4'd0);
    push_beat(8'h03, 1'b0, 4'd0);
    check("preclear_count", count, 3);
    clear     = 1'b1;
    in_valid  = 1'b1;
    data      = 8'h55;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("clear_count", count, 0);
    check("clear_valid", out_valid, 0);
    check("clear_enc_cnt2", enc_cnt, 0);
    check("clear_ready", in_ready, 1);
    push_beat(8'hFF, 1'b0, 4'd0);
    check("postclear_code", code, 12'hF77);
    check("postclear_enc_cnt", enc_cnt, 1);
    pop_one();

    // asynchronous reset in the middle of a cycle
    push_beat(8'hA5, 1'b0, 4'd0);
    push_beat(8'h5A, 1'b0, 4'd0);
    check("prerst_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", out_valid, 0);
    check("arst_enc_cnt", enc_cnt, 0);
    check("arst_code", code, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    push_beat(8'hFF, 1'b0, 4'd0);
    check("postrst_code", code, 12'hF77);
    check("postrst_count", count, 1);
    pop_one();
    check("postrst_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
